intr_claim_arbiter: RTL

//  Schedules NumSrc level interrupts (the intr_o outputs of per-peripheral interrupt

---
 rtl/intr_claim_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/intr_claim_arbiter.sv
// Interrupt gateway plus arbiter: latches level sources into pending bits, presents one
// registered winner (fixed priority or round-robin) and tracks claim/complete in-service state.
module intr_claim_arbiter #(
    parameter int NumSrc     = 8,
    parameter int IdW        = $clog2(NumSrc + 1),
    parameter bit RoundRobin = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] intr_src_i,
    input  logic [NumSrc-1:0] src_enable_i,
    output logic              irq_o,
    output logic [IdW-1:0]    irq_id_o,
    input  logic              claim_i,
    output logic [IdW-1:0]    claim_id_o,
    input  logic              complete_i,
    input  logic [IdW-1:0]    complete_id_i,
    output logic [NumSrc-1:0] in_service_o
);

    localparam int PtrW = (NumSrc > 1) ? $clog2(NumSrc) : 1;
    localparam logic [NumSrc-1:0] OneHot0 = NumSrc'(1);

    logic [NumSrc-1:0] r_pending;
    logic [NumSrc-1:0] r_in_service;
    logic [PtrW-1:0]   r_ptr;
    logic              r_irq;
    logic [IdW-1:0]    r_irq_id;

    logic [NumSrc-1:0] w_eligible;
    logic [NumSrc-1:0] w_claim_mask;
    logic [NumSrc-1:0] w_complete_mask;
    logic [NumSrc-1:0] w_set_mask;
    logic [PtrW-1:0]   w_scan_base;
    logic [PtrW:0]     w_pick;
    logic              w_found;
    logic [PtrW-1:0]   w_win_idx;
    logic              w_claim_hit;
    logic              w_complete_ok;
    logic [PtrW-1:0]   w_ptr_next;

    // Scan starts at base and wraps; returns {found, index}.
    function automatic logic [PtrW:0] pick_winner(input logic [NumSrc-1:0] elig,
                                                  input logic [PtrW-1:0]   base);
        logic            found;
        logic [PtrW-1:0] idx;
        logic [PtrW-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < NumSrc; j++) begin
            k = PtrW'((int'(base) + j) % NumSrc);
            if (!found && elig[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    assign w_eligible  = r_pending & src_enable_i;
    assign w_scan_base = RoundRobin ? r_ptr : '0;
    assign w_pick      = pick_winner(w_eligible, w_scan_base);
    assign w_found     = w_pick[PtrW];
    assign w_win_idx   = w_pick[PtrW-1:0];

    // A claim is honoured on the registered ID even if the enable has since dropped.
    assign w_claim_hit   = claim_i && (r_irq_id != '0);
    assign w_claim_mask  = w_claim_hit ? (OneHot0 << (r_irq_id - IdW'(1))) : '0;
    assign w_complete_ok = complete_i && (complete_id_i != '0)
                           && (complete_id_i <= IdW'(NumSrc));
    assign w_complete_mask = w_complete_ok
                           ? ((OneHot0 << (complete_id_i - IdW'(1))) & r_in_service) : '0;

    // A source re-arms only once it is neither pending nor in service.
    assign w_set_mask = intr_src_i & ~r_pending & ~r_in_service;
    assign w_ptr_next = (r_irq_id == IdW'(NumSrc)) ? '0 : PtrW'(r_irq_id);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_ptr        <= '0;
            r_irq        <= 1'b0;
            r_irq_id     <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_claim_mask) | w_set_mask;
            r_in_service <= (r_in_service | w_claim_mask) & ~w_complete_mask;
            if (RoundRobin && w_claim_hit) begin
                r_ptr <= w_ptr_next;
            end
            r_irq    <= w_found;
            r_irq_id <= w_found ? (IdW'(w_win_idx) + IdW'(1)) : '0;
        end
    end

    assign irq_o        = r_irq;
    assign irq_id_o     = r_irq_id;
    assign claim_id_o   = r_irq_id;
    assign in_service_o = r_in_service;

endmodule
